// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment scan driver:
//   - bit positions of the a..g segments and the dot inside an abcdefgh byte
//   - 16-entry hex-to-abcdefg table (active-high, a in the MSB)
//   - seg7_decode(): table lookup for one hex nibble
package seg7_pkg;

  // Segment ordering inside the 8-bit abcdefgh bus: bit7=a ... bit1=g, bit0=h.
  localparam int seg_bit_a = 7;
  localparam int seg_bit_g = 1;
  localparam int seg_bit_h = 0;

  typedef logic [6:0] seg7_t;

  // Active-high abcdefg patterns for hex digits 0..F (b and d in lower case).
  localparam seg7_t seg7_table [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  function automatic seg7_t seg7_decode(input logic [3:0] nibble);
    return seg7_table[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder
// Combinational hex digit + dot to active-high abcdefgh pattern.
// Ports:
//   nibble   in  4  hex value to show
//   dot      in  1  dot (h segment) enable
//   abcdefgh out 8  active-high segments, bit7=a ... bit1=g, bit0=h
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dot,
  output logic [7:0] abcdefgh
);

  // Place the decoded a..g pattern and the dot into their bus positions.
  always_comb begin
    abcdefgh                      = 8'h00;
    abcdefgh[seg_bit_a:seg_bit_g] = seg7_decode(nibble);
    abcdefgh[seg_bit_h]           = dot;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a common-segment 7-segment display. The
// packed hex value and dot mask are captured into shadow registers once per
// full scan, so a frame never mixes old and new digits. Each digit slot
// starts with a short all-off gap to suppress ghosting; leading zeros can
// optionally be blanked. Outputs are registered (one cycle behind cnt/idx).
// Ports:
//   clk      in  1          system clock
//   rst      in  1          synchronous active-high reset
//   number   in  w_digit*4  hex value, nibble i -> digit i (digit 0 = LSD)
//   dots     in  w_digit    per-digit dot enable
//   abcdefgh out 8          segments, bit7=a ... bit1=g, bit0=h
//   digit    out w_digit    digit select, one-hot when active
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int clk_mhz             = 50,
  parameter int w_digit             = 8,
  parameter int digit_period        = clk_mhz * 1000,
  parameter int blank_cycles        = digit_period / 16,
  parameter int blank_leading_zeros = 0,
  parameter int seg_active_low      = 1,
  parameter int digit_active_low    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [w_digit*4-1:0] number,
  input  logic [w_digit-1:0]   dots,
  output logic [7:0]           abcdefgh,
  output logic [w_digit-1:0]   digit
);

  localparam int cnt_w = (digit_period > 1) ? $clog2(digit_period) : 1;
  localparam int idx_w = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [cnt_w-1:0] cnt_last  = cnt_w'(digit_period - 1);
  localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);
  localparam logic [cnt_w-1:0] blank_lim = cnt_w'(blank_cycles);
  localparam logic [idx_w-1:0] idx_last  = idx_w'(w_digit - 1);
  localparam logic [idx_w-1:0] idx_one   = idx_w'(1);

  localparam logic              lz_en     = (blank_leading_zeros != 0);
  // XOR masks: all-ones flips an active-high pattern to active-low.
  localparam logic [7:0]         seg_off   = (seg_active_low != 0) ? 8'hFF : 8'h00;
  localparam logic [w_digit-1:0] digit_off = (digit_active_low != 0) ?
                                             {w_digit{1'b1}} : {w_digit{1'b0}};

  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [idx_w-1:0]     idx_q, idx_d;
  logic [w_digit*4-1:0] num_s_q, num_s_d;
  logic [w_digit-1:0]   dots_s_q, dots_s_d;
  logic [w_digit-1:0]   digit_q, digit_d;
  logic [7:0]           abcdefgh_q, abcdefgh_d;

  logic                 cnt_wrap;
  logic                 frame_end;
  logic [w_digit-1:0]   sel_oh;
  logic [3:0]           nib_mux;
  logic                 dot_mux;
  logic                 lz_blank;
  logic                 in_blank;
  logic [7:0]           seg_dec;

  // Slot counter, digit index and end-of-frame shadow capture.
  always_comb begin
    cnt_wrap  = (cnt_q == cnt_last);
    frame_end = cnt_wrap && (idx_q == idx_last);

    if (cnt_wrap) begin
      cnt_d = {cnt_w{1'b0}};
    end else begin
      cnt_d = cnt_q + cnt_one;
    end

    if (cnt_wrap) begin
      if (idx_q == idx_last) begin
        idx_d = {idx_w{1'b0}};
      end else begin
        idx_d = idx_q + idx_one;
      end
    end else begin
      idx_d = idx_q;
    end

    // Inputs are only sampled between frames so a scan is always consistent.
    if (frame_end) begin
      num_s_d  = number;
      dots_s_d = dots;
    end else begin
      num_s_d  = num_s_q;
      dots_s_d = dots_s_q;
    end
  end

  // One-hot decode of the current digit index.
  always_comb begin
    sel_oh = {w_digit{1'b0}};
    for (int i = 0; i < w_digit; i++) begin
      sel_oh[i] = (idx_q == idx_w'(i));
    end
  end

  // Select the shown nibble/dot and decide leading-zero blanking.
  // zero_acc walks from the top digit down, so at digit i it is set only
  // when nibbles i..w_digit-1 are all zero.
  always_comb begin
    logic zero_acc;
    zero_acc = 1'b1;
    nib_mux  = 4'h0;
    dot_mux  = 1'b0;
    lz_blank = 1'b0;
    for (int i = w_digit - 1; i >= 0; i--) begin
      zero_acc = zero_acc & (num_s_q[i*4 +: 4] == 4'h0);
      nib_mux  = nib_mux | ({4{sel_oh[i]}} & num_s_q[i*4 +: 4]);
      dot_mux  = dot_mux | (sel_oh[i] & dots_s_q[i]);
      // Digit 0 always shows; a lit dot keeps a zero digit visible.
      lz_blank = lz_blank | (sel_oh[i] & zero_acc & ~dots_s_q[i] & (i != 0));
    end
    lz_blank = lz_blank & lz_en;
  end

  seg7_hex_decoder u_dec (
    .nibble   (nib_mux),
    .dot      (dot_mux),
    .abcdefgh (seg_dec)
  );

  // Output pattern for the next cycle, polarity applied by XOR mask.
  always_comb begin
    in_blank = (cnt_q < blank_lim);
    if (in_blank || lz_blank) begin
      digit_d    = digit_off;
      abcdefgh_d = seg_off;
    end else begin
      digit_d    = sel_oh ^ digit_off;
      abcdefgh_d = seg_dec ^ seg_off;
    end
  end

  // State and output registers; reset also samples the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= {cnt_w{1'b0}};
      idx_q      <= {idx_w{1'b0}};
      num_s_q    <= number;
      dots_s_q   <= dots;
      digit_q    <= digit_off;
      abcdefgh_q <= seg_off;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      num_s_q    <= num_s_d;
      dots_s_q   <= dots_s_d;
      digit_q    <= digit_d;
      abcdefgh_q <= abcdefgh_d;
    end
  end

  assign abcdefgh = abcdefgh_q;
  assign digit    = digit_q;

endmodule
